// File: rtl/stopwatch_display.sv
// stopwatch_display
// Converts the stopwatch time word {minutes, seconds} to BCD with a
// sequential double-dabble and drives a 4-digit multiplexed 7-segment
// display reading MM.SS.
//
// Ports:
//   clk        system clock
//   nrst       asynchronous active-low reset
//   time_in    {minutes[13:7], seconds[6:0]}, binary 0..127 per field
//   blank      forces seg/dp/digit_sel to zero (combinational)
//   seg        {g,f,e,d,c,b,a}, active-high
//   dp         decimal point, active-high (lit on the minutes-ones digit)
//   digit_sel  one-hot active-high digit enable
//   busy       high while a conversion is in progress (state != IDLE)
//
// Handshake: there is none. time_in is sampled only in IDLE; a mismatch
// against the last captured word starts a conversion, so a value that
// changes mid-conversion is picked up when the FSM returns to IDLE.

module stopwatch_display #(
    parameter int SCAN_DIV = 1000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [13:0] time_in,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_sel,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam int              CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [1:0]    state_q,    state_d;
    logic [13:0]   captured_q, captured_d;
    logic [6:0]    min_sh_q,   min_sh_d;
    logic [6:0]    sec_sh_q,   sec_sh_d;
    logic [7:0]    min_bcd_q,  min_bcd_d;
    logic [7:0]    sec_bcd_q,  sec_bcd_d;
    logic [2:0]    cnt_q,      cnt_d;
    logic [15:0]   disp_q,     disp_d;     // {min_tens, min_ones, sec_tens, sec_ones}
    logic [CW-1:0] scan_q,     scan_d;
    logic [1:0]    idx_q,      idx_d;

    // Add-3 correction on every BCD nibble that is 5 or more, applied
    // before each left shift.
    function automatic logic [7:0] dabble(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

    // Conversion FSM
    always_comb begin
        logic [7:0] min_adj;
        logic [7:0] sec_adj;
        state_d    = state_q;
        captured_d = captured_q;
        min_sh_d   = min_sh_q;
        sec_sh_d   = sec_sh_q;
        min_bcd_d  = min_bcd_q;
        sec_bcd_d  = sec_bcd_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        min_adj    = dabble(min_bcd_q);
        sec_adj    = dabble(sec_bcd_q);
        case (state_q)
            IDLE: begin
                if (time_in != captured_q) begin
                    captured_d = time_in;
                    min_sh_d   = time_in[13:7];
                    sec_sh_d   = time_in[6:0];
                    min_bcd_d  = 8'h00;
                    sec_bcd_d  = 8'h00;
                    cnt_d      = 3'd0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                min_bcd_d = {min_adj[6:0], min_sh_q[6]};
                sec_bcd_d = {sec_adj[6:0], sec_sh_q[6]};
                min_sh_d  = {min_sh_q[5:0], 1'b0};
                sec_sh_d  = {sec_sh_q[5:0], 1'b0};
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd6) state_d = COMMIT;
            end
            COMMIT: begin
                // The 8-bit accumulators cannot hold the hundreds digit, so
                // the clamp keys off the captured binary field instead.
                disp_d[15:8] = (captured_q[13:7] > 7'd99) ? 8'h99 : min_bcd_q;
                disp_d[7:0]  = (captured_q[6:0]  > 7'd99) ? 8'h99 : sec_bcd_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan timing, free-running regardless of FSM and blank
    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            captured_q <= '0;
            min_sh_q   <= '0;
            sec_sh_q   <= '0;
            min_bcd_q  <= '0;
            sec_bcd_q  <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            min_sh_q   <= min_sh_d;
            sec_sh_q   <= sec_sh_d;
            min_bcd_q  <= min_bcd_d;
            sec_bcd_q  <= sec_bcd_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
        end
    end

    assign busy = (state_q != IDLE);

    // Digit select and segment decode
    always_comb begin
        logic [3:0] digit;
        logic [6:0] seg_raw;
        case (idx_q)
            2'd0:    digit = disp_q[3:0];
            2'd1:    digit = disp_q[7:4];
            2'd2:    digit = disp_q[11:8];
            default: digit = disp_q[15:12];
        endcase
        case (digit)
            4'd0:    seg_raw = 7'h3F;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5B;
            4'd3:    seg_raw = 7'h4F;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6D;
            4'd6:    seg_raw = 7'h7D;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h6F;
            default: seg_raw = 7'h00;
        endcase
        if (LZ_BLANK && (idx_q == 2'd3) && (digit == 4'd0)) seg_raw = 7'h00;
        if (blank) begin
            seg       = 7'h00;
            dp        = 1'b0;
            digit_sel = 4'b0000;
        end else begin
            seg       = seg_raw;
            dp        = (idx_q == 2'd2);
            digit_sel = 4'b0001 << idx_q;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic [13:0] time_in;
    logic        blank;
    logic [6:0]  seg,  seg_lz;
    logic        dp,   dp_lz;
    logic [3:0]  digit_sel, digit_sel_lz;
    logic        busy, busy_lz;

    int checks   = 0;
    int failures = 0;
    int n_edges  = 0;          // clock edges since reset release
    logic [13:0] shown;        // time word the display is expected to show

    stopwatch_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .nrst(nrst), .time_in(time_in), .blank(blank),
        .seg(seg), .dp(dp), .digit_sel(digit_sel), .busy(busy)
    );

    stopwatch_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .nrst(nrst), .time_in(time_in), .blank(blank),
        .seg(seg_lz), .dp(dp_lz), .digit_sel(digit_sel_lz), .busy(busy_lz)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    // Reference: which digit is being scanned, from elapsed edges only.
    function automatic int exp_idx();
        return (n_edges / SD) % 4;
    endfunction

    // Reference segment pattern for time word t on digit idx.
    function automatic logic [6:0] exp_seg(input logic [13:0] t, input int idx, input bit lz);
        int m, s, d;
        m = (int'(t[13:7]) > 99) ? 99 : int'(t[13:7]);
        s = (int'(t[6:0])  > 99) ? 99 : int'(t[6:0]);
        case (idx)
            0: d = s % 10;
            1: d = s / 10;
            2: d = m % 10;
            default: d = m / 10;
        endcase
        if (lz && idx == 3 && d == 0) return 7'h00;
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    task automatic test_reset();
        nrst = 1'b0; time_in = '0; blank = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (digit_sel !== 4'b0001) begin failures++; $display("FAIL rst_digit_sel: got %b expected 0001", digit_sel); end
        checks++; if (seg !== 7'h3F) begin failures++; $display("FAIL rst_seg: got %h expected 3f", seg); end
        checks++; if (dp !== 1'b0) begin failures++; $display("FAIL rst_dp: got %b expected 0", dp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        nrst = 1'b1;
        shown = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy k=%0d: got %b expected 0", k, busy); end
            checks++; if (seg !== exp_seg(shown, exp_idx(), 1'b0)) begin failures++; $display("FAIL idle_seg k=%0d: got %h expected %h", k, seg, exp_seg(shown, exp_idx(), 1'b0)); end
        end
    endtask

    // Drives val (must differ from the displayed word), checks busy timing,
    // then the displayed value over a full scan on both instances.
    task automatic test_convert(input logic [13:0] val);
        int idx;
        time_in = val;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k < 8)) begin failures++; $display("FAIL conv_busy val=%h k=%0d: got %b expected %b", val, k, busy, (k < 8)); end
        end
        shown = val;
        for (int k = 0; k < 4 * SD; k++) begin
            if (k > 0) @(negedge clk);
            idx = exp_idx();
            checks++; if (digit_sel !== (4'b0001 << idx)) begin failures++; $display("FAIL conv_digit_sel val=%h: got %b expected %b", val, digit_sel, 4'b0001 << idx); end
            checks++; if (seg !== exp_seg(val, idx, 1'b0)) begin failures++; $display("FAIL conv_seg val=%h idx=%0d: got %h expected %h", val, idx, seg, exp_seg(val, idx, 1'b0)); end
            checks++; if (dp !== (idx == 2)) begin failures++; $display("FAIL conv_dp val=%h idx=%0d: got %b expected %b", val, idx, dp, (idx == 2)); end
            checks++; if (seg_lz !== exp_seg(val, idx, 1'b1)) begin failures++; $display("FAIL conv_seg_lz val=%h idx=%0d: got %h expected %h", val, idx, seg_lz, exp_seg(val, idx, 1'b1)); end
        end
    endtask

    task automatic test_random();
        logic [13:0] v;
        for (int i = 0; i < 8; i++) begin
            do v = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))}; while (v == shown);
            test_convert(v);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] prev, exp_disp;
        logic        exp_busy;
        prev = shown;
        time_in = 14'd5;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) time_in = 14'd6;
            if (k == 1) time_in = 14'd7;
            exp_busy = (k <= 7) || (k >= 9 && k <= 16);
            exp_disp = (k < 8) ? prev : ((k < 17) ? 14'd5 : 14'd7);
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL b2b_busy k=%0d: got %b expected %b", k, busy, exp_busy); end
            checks++; if (seg !== exp_seg(exp_disp, exp_idx(), 1'b0)) begin failures++; $display("FAIL b2b_seg k=%0d: got %h expected %h", k, seg, exp_seg(exp_disp, exp_idx(), 1'b0)); end
        end
        shown = 14'd7;
    endtask

    task automatic test_scan_blank();
        for (int k = 0; k < 8 * SD; k++) begin
            @(negedge clk);
            checks++; if (digit_sel !== (4'b0001 << exp_idx())) begin failures++; $display("FAIL scan_sel k=%0d: got %b expected %b", k, digit_sel, 4'b0001 << exp_idx()); end
        end
        blank = 1'b1;
        for (int k = 0; k < 3 * SD + 1; k++) begin
            @(negedge clk);
            checks++; if ({seg, dp, digit_sel} !== 12'h000) begin failures++; $display("FAIL blank_out k=%0d: got %h expected 000", k, {seg, dp, digit_sel}); end
            checks++; if ({seg_lz, dp_lz, digit_sel_lz} !== 12'h000) begin failures++; $display("FAIL blank_out_lz k=%0d: got %h expected 000", k, {seg_lz, dp_lz, digit_sel_lz}); end
        end
        blank = 1'b0;
        #1;
        checks++; if (digit_sel !== (4'b0001 << exp_idx())) begin failures++; $display("FAIL unblank_sel: got %b expected %b", digit_sel, 4'b0001 << exp_idx()); end
    endtask

    task automatic test_lz();
        bit seen = 0;
        test_convert({7'd5, 7'd42});
        for (int k = 0; k < 4 * SD && !seen; k++) begin
            @(negedge clk);
            if (digit_sel_lz == 4'b1000) begin
                seen = 1;
                checks++; if (seg_lz !== 7'h00) begin failures++; $display("FAIL lz_blank: got %h expected 00", seg_lz); end
                checks++; if (seg !== 7'h3F) begin failures++; $display("FAIL lz_off: got %h expected 3f", seg); end
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL lz_digit3_timeout: got none expected 1000"); end
    endtask

    task automatic test_reset_mid();
        time_in = {7'd59, 7'd59};
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
        nrst = 1'b0;
        shown = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_rst: got %b expected 0", busy); end
        checks++; if (digit_sel !== 4'b0001) begin failures++; $display("FAIL mid_sel_rst: got %b expected 0001", digit_sel); end
        checks++; if (seg !== 7'h3F) begin failures++; $display("FAIL mid_seg_rst: got %h expected 3f", seg); end
        repeat (2) @(negedge clk);
        checks++; if (seg !== 7'h3F) begin failures++; $display("FAIL mid_seg_hold: got %h expected 3f", seg); end
        nrst = 1'b1;
        test_convert({7'd59, 7'd59});
    endtask

    initial begin
        test_reset();
        test_convert({7'd12, 7'd34});
        test_convert({7'd127, 7'd100});
        test_back_to_back();
        test_random();
        test_scan_blank();
        test_lz();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
